ioctl_upload_server: RTL and testbench
======================================

// Module: ioctl_upload_server
// PURPOSE
//  Upload-direction counterpart of the HPS ioctl download path: serves HPS byte reads
//  (ioctl_upload/ioctl_rd) from an on-chip save RAM (hiscore/NVRAM) so the HPS can store it.
//  Sits between hps_io upload signals and the read port of a dual-port RAM in the core.
//  Stalls the HPS with ioctl_wait while the RAM read is in flight.
// PARAMETERS
//  UPLOAD_INDEX  8'd4   ioctl_index value this server answers; others ignored
//  AW            10     RAM address width
//  SIZE          1024   bytes served; addr >= SIZE returns FILL without a RAM access
//  RAM_LAT       1      RAM read latency in clocks (1..7)
//  FILL          8'hFF  byte returned for out-of-range addresses
// PORTS
//  clk_sys       in   1   system clock, all logic on rising edge
//  reset_n       in   1   synchronous reset, active low
//  ioctl_upload  in   1   HPS upload in progress
//  ioctl_index   in   8   upload target index
//  ioctl_rd      in   1   one-cycle read strobe from HPS
//  ioctl_addr    in   25  byte address of the read
//  ioctl_din     out  8   data returned to HPS
//  ioctl_wait    out  1   stall HPS while high
//  ram_addr      out  AW  RAM read address
//  ram_rd        out  1   one-cycle RAM read enable
//  ram_dout      in   8   RAM read data, valid RAM_LAT clocks after ram_rd
//  busy          out  1   read in flight (state != IDLE)
//  done          out  1   one-cycle pulse when an upload session ends
//  byte_count    out  16  bytes served this session, saturates at 16'hFFFF
//  overrun       out  1   sticky: ioctl_rd seen while busy; cleared on new session
// BEHAVIOUR
//  - active = ioctl_upload && ioctl_index==UPLOAD_INDEX; registered copy active_q.
//  - reset_n=0: state=IDLE; ioctl_din=0, ioctl_wait=0, ram_addr=0, ram_rd=0, done=0,
//    byte_count=0, overrun=0, active_q=0. Reset mid-read abandons it; no done pulse.
//  - Session start (active & !active_q): byte_count<=0, overrun<=0.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE:
//    IDLE: rd = active & ioctl_rd. If rd and ioctl_addr<SIZE: ram_addr<=ioctl_addr[AW-1:0],
//      ioctl_wait<=1, ->ISSUE. If rd and ioctl_addr>=SIZE: ioctl_din<=FILL, byte_count+1,
//      stay IDLE, ioctl_wait stays 0 (data valid next clock).
//    ISSUE: ram_rd=1 for exactly this clock; load lat counter=RAM_LAT; ->WAIT.
//    WAIT: decrement counter; on last count ioctl_din<=ram_dout, ioctl_wait<=0,
//      byte_count+1, ->IDLE.
//  - Timing (rd sampled at clock 0): ioctl_wait high clocks 1..RAM_LAT+1; ioctl_din
//    valid and ioctl_wait low at clock RAM_LAT+2. ram_rd high in clock 1 only.
//  - ioctl_din holds last value between reads; ram_addr holds last address.
//  - ioctl_rd while busy: ignored (no requeue), overrun<=1.
//  - ioctl_rd with !active, or index mismatch: ignored, no state change, no overrun.
//  - active drops mid-read: read completes normally (wait released, count bumped); done
//    pulses one clock after the later of (active falling, FSM back in IDLE).
//  - active falling while IDLE: done=1 the next clock for one clock.
//  - Address compare uses full 25-bit ioctl_addr; upper bits never wrap into RAM.
//  - byte_count: +1 per served byte (RAM or FILL), saturates, never wraps.
// TESTING
//  1 RAM_LAT=1, RAM[5]=8'hA7, rd addr 5 at clk0 -> ram_rd clk1, wait clk1..2, din=A7 clk3.
//  2 RAM_LAT=3, sweep addr 0..1023 with HPS honouring wait -> bytes match RAM, count=1024,
//    wait high 4 clocks per read.
//  3 rd addr 1024 and 25'h1000005 -> din=FF next clock, wait never high, ram_rd never high.
//  4 ioctl_index=3 with rd -> no ram_rd, wait 0, count 0; second rd during wait -> overrun=1,
//    cleared on next session start.
//  5 drop ioctl_upload in clock 2 of a RAM_LAT=3 read -> din valid, wait low on schedule,
//    done one pulse the clock after.
//  6 reset_n low during WAIT -> next clock all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server
// Serves HPS upload byte reads (ioctl_upload / ioctl_rd) from the read port of an
// on-chip save RAM so the HPS can store hiscore/NVRAM contents.
// Holds ioctl_wait high while a RAM read is in flight.
// Addresses at or beyond SIZE return FILL without touching the RAM.
//
// Ports
//   clk_sys       system clock, everything on the rising edge
//   reset_n       synchronous reset, active low
//   ioctl_upload  HPS upload in progress
//   ioctl_index   upload target index; only UPLOAD_INDEX is answered
//   ioctl_rd      one-cycle read strobe from the HPS
//   ioctl_addr    25-bit byte address of the read
//   ioctl_din     byte returned to the HPS; holds between reads
//   ioctl_wait    stall to the HPS while a RAM read is outstanding
//   ram_addr      RAM read address; holds the last address issued
//   ram_rd        one-cycle RAM read enable
//   ram_dout      RAM read data, valid RAM_LAT clocks after ram_rd
//   busy          read in flight
//   done          one-cycle pulse when an upload session ends
//   byte_count    bytes served this session, saturating
//   overrun       sticky flag: read strobe seen while busy
//
// FSM
//   state   | meaning
//   S_IDLE  | waiting for a read strobe; out-of-range reads answered here
//   S_ISSUE | ram_rd asserted for this single clock; latency counter loaded
//   S_WAIT  | counting down RAM latency; data captured on the last count

module ioctl_upload_server #(
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         AW           = 10,
    parameter int         SIZE         = 1024,
    parameter int         RAM_LAT      = 1,
    parameter logic [7:0] FILL         = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    output logic          busy,
    output logic          done,
    output logic [15:0]   byte_count,
    output logic          overrun
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;

    localparam logic [24:0] SIZE_A  = 25'(SIZE);
    localparam logic [2:0]  LAT     = 3'(RAM_LAT);

    logic [1:0]  state;
    logic [2:0]  lat_cnt;
    logic        active;
    logic        active_q;
    logic        session_start;
    logic        active_fall;
    logic        done_pending;
    logic        rd_req;
    logic        in_range;
    logic        lat_last;
    logic        served;
    logic [15:0] count_base;

    assign active        = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign session_start = active && !active_q;
    assign active_fall   = !active && active_q;
    assign rd_req        = active && ioctl_rd;
    // Full 25-bit compare so high address bits can never alias into the RAM.
    assign in_range      = ioctl_addr < SIZE_A;
    assign lat_last      = (state == S_WAIT) && (lat_cnt == 3'd1);

    // A byte is served either immediately (fill) or when RAM data is captured.
    assign served        = ((state == S_IDLE) && rd_req && !in_range) || lat_last;

    // A session start clears the count in the same clock a byte may be served,
    // so the increment is applied on top of the cleared value.
    assign count_base    = session_start ? 16'd0 : byte_count;

    assign ram_rd        = (state == S_ISSUE);
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            lat_cnt      <= 3'd0;
            ioctl_din    <= 8'd0;
            ioctl_wait   <= 1'b0;
            ram_addr     <= '0;
            done         <= 1'b0;
            done_pending <= 1'b0;
            byte_count   <= 16'd0;
            overrun      <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            active_q <= active;

            if (served && (count_base != 16'hFFFF)) begin
                byte_count <= count_base + 16'd1;
            end else begin
                byte_count <= count_base;
            end

            if (busy && rd_req) begin
                overrun <= 1'b1;
            end else if (session_start) begin
                overrun <= 1'b0;
            end

            // End of session is reported only once the FSM is back in idle, so a
            // read that outlives the session still finishes before done.
            if ((state == S_IDLE) && (active_fall || done_pending)) begin
                done         <= 1'b1;
                done_pending <= 1'b0;
            end else begin
                done         <= 1'b0;
                done_pending <= done_pending || active_fall;
            end

            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        if (in_range) begin
                            ram_addr   <= ioctl_addr[AW-1:0];
                            ioctl_wait <= 1'b1;
                            state      <= S_ISSUE;
                        end else begin
                            ioctl_din  <= FILL;
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        ioctl_din  <= ram_dout;
                        ioctl_wait <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: two instances (RAM_LAT=1 as unit 0, RAM_LAT=3 as
// unit 1), each with its own latency-accurate RAM model sharing one content array.
module tb_ioctl_upload_server;

    logic clk;
    logic reset_n;

    logic [1:0]        upload;
    logic [1:0][7:0]   index;
    logic [1:0]        rd;
    logic [1:0][24:0]  addr;
    logic [1:0][7:0]   ram_dout;

    wire  [1:0][7:0]   din_o;
    wire  [1:0]        wait_o;
    wire  [1:0][9:0]   ram_addr_o;
    wire  [1:0]        ram_rd_o;
    wire  [1:0]        busy_o;
    wire  [1:0]        done_o;
    wire  [1:0][15:0]  bc_o;
    wire  [1:0]        ovr_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [1024];
    logic [7:0] pipe [2][8];
    logic [1:0][7:0] vld;

    ioctl_upload_server #(.RAM_LAT(1)) u_lat1 (
        .clk_sys(clk), .reset_n(reset_n),
        .ioctl_upload(upload[0]), .ioctl_index(index[0]), .ioctl_rd(rd[0]),
        .ioctl_addr(addr[0]), .ioctl_din(din_o[0]), .ioctl_wait(wait_o[0]),
        .ram_addr(ram_addr_o[0]), .ram_rd(ram_rd_o[0]), .ram_dout(ram_dout[0]),
        .busy(busy_o[0]), .done(done_o[0]), .byte_count(bc_o[0]), .overrun(ovr_o[0])
    );

    ioctl_upload_server #(.RAM_LAT(3)) u_lat3 (
        .clk_sys(clk), .reset_n(reset_n),
        .ioctl_upload(upload[1]), .ioctl_index(index[1]), .ioctl_rd(rd[1]),
        .ioctl_addr(addr[1]), .ioctl_din(din_o[1]), .ioctl_wait(wait_o[1]),
        .ram_addr(ram_addr_o[1]), .ram_rd(ram_rd_o[1]), .ram_dout(ram_dout[1]),
        .busy(busy_o[1]), .done(done_o[1]), .byte_count(bc_o[1]), .overrun(ovr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // RAM: data presented only in the single clock that is RAM_LAT after ram_rd.
    initial vld = '0;
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int k = 7; k > 0; k--) begin
                pipe[u][k] <= pipe[u][k-1];
                vld[u][k]  <= vld[u][k-1];
            end
            pipe[u][0] <= mem[ram_addr_o[u]];
            vld[u][0]  <= ram_rd_o[u];
        end
    end

    always_comb begin
        ram_dout = '0;
        for (int u = 0; u < 2; u++) begin
            ram_dout[u] = vld[u][lat(u)-1] ? pipe[u][lat(u)-1] : 8'h00;
        end
    end

    task automatic chk(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit%0d: got %0h expected %0h", name, u, act, exp);
        end
    endtask

    // Reference byte for an address: RAM content below 1024, fill byte otherwise.
    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        logic [9:0] ai;
        ai = a[9:0];
        return (a < 25'd1024) ? mem[ai] : 8'hFF;
    endfunction

    // One HPS read honouring ioctl_wait; samples begin at clock 1 after the strobe.
    task automatic do_read(input int u, input logic [24:0] a, output logic [7:0] d,
                           output int wcyc, output int rcyc, output bit rd_first,
                           output bit done_seen, output bit timeout);
        addr[u] = a;
        rd[u]   = 1'b1;
        @(negedge clk);
        rd[u]     = 1'b0;
        wcyc      = 0;
        rcyc      = 0;
        rd_first  = ram_rd_o[u];
        done_seen = 1'b0;
        timeout   = 1'b0;
        while (wait_o[u]) begin
            wcyc++;
            if (ram_rd_o[u]) rcyc++;
            if (done_o[u]) done_seen = 1'b1;
            if (wcyc > 16) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ram_rd_o[u]) rcyc++;
        if (done_o[u]) done_seen = 1'b1;
        d = din_o[u];
    endtask

    task automatic chk_reset(input int u);
        chk("rst_din", u, 32'(din_o[u]), 32'h0);
        chk("rst_wait", u, 32'(wait_o[u]), 32'h0);
        chk("rst_ram_addr", u, 32'(ram_addr_o[u]), 32'h0);
        chk("rst_ram_rd", u, 32'(ram_rd_o[u]), 32'h0);
        chk("rst_busy", u, 32'(busy_o[u]), 32'h0);
        chk("rst_done", u, 32'(done_o[u]), 32'h0);
        chk("rst_count", u, 32'(bc_o[u]), 32'h0);
        chk("rst_overrun", u, 32'(ovr_o[u]), 32'h0);
    endtask

    typedef struct {
        int          u;
        logic [24:0] a;
        logic [7:0]  din;
        int          wcyc;
        bit          rdh;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0]  d;
        int          wcyc, rcyc;
        bit          rd_first, done_seen, timeout;
        logic [7:0]  wv, dv;
        int          rc;
        logic        ovr3;
        logic [7:0]  d5;
        int          exp_cnt [2];
        logic [7:0]  exp_din [2];
        logic [9:0]  exp_raddr [2];
        bit          act_m [2];

        tbl[0] = '{0, 25'd5,         8'hA7, 2, 1'b1};
        tbl[1] = '{1, 25'd5,         8'hA7, 4, 1'b1};
        tbl[2] = '{1, 25'd0,         8'h11, 4, 1'b1};
        tbl[3] = '{1, 25'd1023,      8'h3C, 4, 1'b1};
        tbl[4] = '{1, 25'd1024,      8'hFF, 0, 1'b0};
        tbl[5] = '{1, 25'h1000005,   8'hFF, 0, 1'b0};
        tbl[6] = '{0, 25'd1024,      8'hFF, 0, 1'b0};
        tbl[7] = '{0, 25'd1023,      8'h3C, 2, 1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[0]    = 8'h11;
        mem[5]    = 8'hA7;
        mem[1023] = 8'h3C;

        reset_n = 1'b0;
        upload  = '0;
        index   = '0;
        rd      = '0;
        addr    = '0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        reset_n = 1'b1;

        // Reads aimed at another index, or with upload low, are ignored.
        upload[1] = 1'b1;
        index[1]  = 8'd3;
        @(negedge clk);
        do_read(1, 25'd5, d, wcyc, rcyc, rd_first, done_seen, timeout);
        chk("idx_mismatch_wait", 1, 32'(wcyc), 32'd0);
        chk("idx_mismatch_ram_rd", 1, 32'(rcyc), 32'd0);
        chk("idx_mismatch_count", 1, 32'(bc_o[1]), 32'd0);
        chk("idx_mismatch_din", 1, 32'(d), 32'h0);
        chk("idx_mismatch_overrun", 1, 32'(ovr_o[1]), 32'd0);
        upload[1] = 1'b0;
        index[1]  = 8'd4;
        do_read(1, 25'd5, d, wcyc, rcyc, rd_first, done_seen, timeout);
        chk("no_upload_ram_rd", 1, 32'(rcyc + wcyc), 32'd0);
        chk("no_upload_count", 1, 32'(bc_o[1]), 32'd0);

        // Second strobe during a read: flagged, not requeued.
        upload[1] = 1'b1;
        @(negedge clk);
        addr[1] = 25'd7;
        rd[1]   = 1'b1;
        wv = '0; dv = '0; rc = 0; ovr3 = 1'b0; d5 = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            wv[c] = wait_o[1];
            if (ram_rd_o[1]) rc++;
            if (c == 3) ovr3 = ovr_o[1];
            if (c == 5) d5 = din_o[1];
            if (c == 1) rd[1] = 1'b0;
            if (c == 2) rd[1] = 1'b1;
            if (c == 3) rd[1] = 1'b0;
        end
        chk("overrun_set", 1, 32'(ovr3), 32'd1);
        chk("overrun_wait_pattern", 1, 32'(wv), 32'h1E);
        chk("overrun_ram_rd_count", 1, 32'(rc), 32'd1);
        chk("overrun_din", 1, 32'(d5), 32'(mem[7]));
        chk("overrun_count", 1, 32'(bc_o[1]), 32'd1);
        chk("overrun_sticky", 1, 32'(ovr_o[1]), 32'd1);
        upload[1] = 1'b0;
        @(negedge clk);
        upload[1] = 1'b1;
        @(negedge clk);
        chk("overrun_cleared", 1, 32'(ovr_o[1]), 32'd0);
        chk("session_count_cleared", 1, 32'(bc_o[1]), 32'd0);

        upload[0] = 1'b1;
        index[0]  = 8'd4;
        @(negedge clk);

        exp_cnt   = '{0, 0};
        exp_raddr = '{10'd0, 10'd7};
        foreach (tbl[i]) begin
            do_read(tbl[i].u, tbl[i].a, d, wcyc, rcyc, rd_first, done_seen, timeout);
            chk("tbl_din", tbl[i].u, 32'(d), 32'(tbl[i].din));
            chk("tbl_wait_clocks", tbl[i].u, 32'(wcyc), 32'(tbl[i].wcyc));
            chk("tbl_ram_rd_clk1", tbl[i].u, 32'(rd_first), 32'(tbl[i].rdh));
            chk("tbl_ram_rd_count", tbl[i].u, 32'(rcyc), 32'(tbl[i].rdh));
            chk("tbl_timeout", tbl[i].u, 32'(timeout), 32'd0);
            exp_cnt[tbl[i].u]++;
            exp_din[tbl[i].u] = tbl[i].din;
            if (tbl[i].rdh) exp_raddr[tbl[i].u] = tbl[i].a[9:0];
            chk("tbl_ram_addr", tbl[i].u, 32'(ram_addr_o[tbl[i].u]), 32'(exp_raddr[tbl[i].u]));
            chk("tbl_count", tbl[i].u, 32'(bc_o[tbl[i].u]), 32'(exp_cnt[tbl[i].u]));
        end

        // New session on unit 1, then sweep the whole RAM.
        upload[1] = 1'b0;
        @(negedge clk);
        chk("idle_done_pulse", 1, 32'(done_o[1]), 32'd1);
        upload[1] = 1'b1;
        @(negedge clk);
        chk("idle_done_single", 1, 32'(done_o[1]), 32'd0);
        chk("sweep_count_start", 1, 32'(bc_o[1]), 32'd0);
        for (int a = 0; a < 1024; a++) begin
            do_read(1, 25'(a), d, wcyc, rcyc, rd_first, done_seen, timeout);
            chk("sweep_din", 1, 32'(d), 32'(mem[a]));
            chk("sweep_wait_clocks", 1, 32'(wcyc), 32'd4);
        end
        chk("sweep_count", 1, 32'(bc_o[1]), 32'd1024);
        exp_cnt[1] = 1024;
        exp_din[1] = mem[1023];

        // Randomized reads against the reference model.
        act_m = '{1'b1, 1'b1};
        for (int i = 0; i < 400; i++) begin
            int          u, kind;
            logic [7:0]  idx;
            logic [24:0] a;
            bit          new_act, fall;
            int          ew;
            u = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 9) begin
                idx = 8'($urandom_range(0, 255));
                if (idx == 8'd4) idx = 8'd5;
            end else begin
                idx = 8'd4;
            end
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    a = 25'($urandom_range(0, 1023));
                2:       a = 25'($urandom_range(1024, 33554431));
                default: a = ($urandom_range(0, 1) == 0) ? 25'd1023 : 25'd1024;
            endcase
            new_act  = (idx == 8'd4);
            fall     = act_m[u] && !new_act;
            index[u] = idx;
            if (new_act && !act_m[u]) exp_cnt[u] = 0;
            ew = 0;
            if (new_act) begin
                exp_din[u] = ref_byte(a);
                if (exp_cnt[u] < 65535) exp_cnt[u]++;
                if (a < 25'd1024) ew = lat(u) + 1;
            end
            do_read(u, a, d, wcyc, rcyc, rd_first, done_seen, timeout);
            chk("rnd_din", u, 32'(d), 32'(exp_din[u]));
            chk("rnd_wait_clocks", u, 32'(wcyc), 32'(ew));
            chk("rnd_ram_rd_count", u, 32'(rcyc), (ew > 0) ? 32'd1 : 32'd0);
            chk("rnd_done", u, 32'(done_seen), 32'(fall));
            chk("rnd_count", u, 32'(bc_o[u]), 32'(exp_cnt[u]));
            chk("rnd_timeout", u, 32'(timeout), 32'd0);
            act_m[u] = new_act;
        end
        chk("rnd_overrun", 0, 32'(ovr_o[0]), 32'd0);
        chk("rnd_overrun", 1, 32'(ovr_o[1]), 32'd0);

        // Upload dropped in clock 2 of a RAM_LAT=3 read.
        index[1] = 8'd4;
        @(negedge clk);
        addr[1] = 25'd9;
        rd[1]   = 1'b1;
        wv = '0; dv = '0; d5 = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            wv[c] = wait_o[1];
            dv[c] = done_o[1];
            if (c == 5) d5 = din_o[1];
            if (c == 1) rd[1] = 1'b0;
            if (c == 2) upload[1] = 1'b0;
        end
        chk("drop_wait_pattern", 1, 32'(wv), 32'h1E);
        chk("drop_done_pattern", 1, 32'(dv), 32'h40);
        chk("drop_din", 1, 32'(d5), 32'(mem[9]));

        // Reset while waiting on the RAM.
        upload[1] = 1'b1;
        @(negedge clk);
        addr[1] = 25'd10;
        rd[1]   = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 1, 32'(busy_o[1]), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset(1);
        reset_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_o[1] || wait_o[1]) done_seen = 1'b1;
        end
        chk("post_reset_quiet", 1, 32'(done_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
